multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the RV64I core. Sequences fetch/decode/execute/memory/writeback over the shared datapath.
//  Drives the immediate-format select into the immediate/sign-extend path, ALU operand muxes, PC/IR enables, memory handshake.
//  Sits between the instruction register and all datapath enables; one instruction in flight.
// PARAMETERS
//  MEM_TIMEOUT_CYC  255  max cycles waiting on i_mem_ready before ERROR; 0 = wait forever
// PORTS
//  i_clk           in   1   clock
//  i_rst_n         in   1   asynchronous active-low reset
//  i_instr         in   32  instruction register contents (valid from DECODE onward)
//  i_mem_ready     in   1   memory completes current request this cycle
//  i_branch_taken  in   1   ALU comparison result for the current BRANCH
//  o_pc_write      out  1   PC register enable
//  o_pc_sel        out  2   0=PC+4, 1=branch/jal target (old_pc+imm), 2=ALU result (JALR, bit0 cleared)
//  o_ir_write      out  1   latch fetched word into IR and old_pc
//  o_mem_req       out  1   memory request, held until i_mem_ready
//  o_mem_we        out  1   store when 1 (valid only with o_mem_req)
//  o_mem_addr_sel  out  1   0=PC, 1=ALU result
//  o_imm_sel       out  3   imm_fmt_t: I,S,B,U,J fed to immediate/sign-extend path
//  o_alu_src_a     out  2   0=rs1, 1=old_pc, 2=zero
//  o_alu_src_b     out  2   0=rs2, 1=imm, 2=const 4
//  o_alu_op        out  2   0=ADD, 1=SUB/compare, 2=funct3/funct7 decode
//  o_reg_write     out  1   register file write enable
//  o_wb_sel        out  2   0=ALU, 1=mem data, 2=PC+4 (old_pc+4)
//  o_illegal       out  1   sticky: unsupported opcode or memory timeout
//  o_state         out  4   current state (debug)
//  o_cycle_cnt     out  64  cycles since reset (CTRL_PERF_CNT_EN)
//  o_instret_cnt   out  64  retired instructions (CTRL_PERF_CNT_EN)
// BEHAVIOUR
//  - Reset: state=FETCH, all enables/strobes 0, o_imm_sel=I, selects 0, o_illegal=0, counters 0.
//  - Moore outputs decoded from registered state; no combinational path from i_instr to any enable except o_imm_sel/o_alu_op.
//  - FETCH: mem_req=1, addr_sel=0; hold until i_mem_ready. On ready: ir_write=1, pc_write=1 with pc_sel=0 -> DECODE.
//  - DECODE (1 cyc): o_imm_sel from opcode; ALU computes old_pc+imm. Next state by opcode[6:0]:
//    0110011 OP->EXEC_R; 0010011 OP-IMM->EXEC_I; 0000011 LOAD / 0100011 STORE->MEM_ADDR;
//    1100011->BRANCH; 1101111 JAL / 1100111 JALR->JUMP; 0110111 LUI / 0010111 AUIPC->EXEC_U; other->ERROR.
//  - EXEC_R/EXEC_I: alu_op=2, src_b=rs2/imm -> WB_ALU. EXEC_U: src_a=zero(LUI)/old_pc(AUIPC), src_b=imm -> WB_ALU.
//  - MEM_ADDR (1 cyc): src_a=rs1, src_b=imm, ADD -> MEM_ACC.
//  - MEM_ACC: mem_req=1, addr_sel=1, we=STORE; hold until ready. LOAD->WB_MEM; STORE->FETCH (retire).
//  - WB_ALU/WB_MEM: reg_write=1 one cycle, wb_sel=0/1 -> FETCH (retire).
//  - BRANCH (1 cyc): alu_op=1 rs1 vs rs2; pc_write=i_branch_taken, pc_sel=1 -> FETCH (retire).
//  - JUMP (1 cyc): reg_write=1, wb_sel=2, pc_write=1, pc_sel=1 (JAL) / 2 (JALR) -> FETCH (retire).
//  - rd==x0 is not special-cased here; the register file drops x0 writes.
//  - Timeout: wait counter clears on entering FETCH/MEM_ACC, increments each cycle without ready; reaching
//    MEM_TIMEOUT_CYC -> ERROR. i_mem_ready in the same cycle the limit is reached wins (no error).
//  - ERROR: o_illegal=1, all enables 0, absorbing until i_rst_n low.
//  - Reset asserted mid-access drops o_mem_req immediately (async); next fetch restarts at PC reset value.
//  - Retire = transition into FETCH from any non-FETCH, non-ERROR state.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined: o_cycle_cnt +1 every cycle out of reset (wraps at 2^64),
//    o_instret_cnt +1 per retire; both frozen in ERROR.
//  Not defined: counter flops absent, both outputs tied to 64'd0.
// STRUCTURE
//  riscv_ctrl_pkg: ctrl_state_t enum (4 bit), imm_fmt_t, alu_op_t, pc_sel_t, wb_sel_t, OPC_* opcode constants.
//  Sub-module ctrl_opdecode: combinational opcode -> {next_state class, imm_fmt_t, is_store}; FSM/counters in top.
// TESTING
//  1. ADDI x1,x0,5 (0x00500093), ready after 2 cyc -> FETCH(3)->DECODE->EXEC_I->WB_ALU; imm_sel=I, reg_write 1 cyc; instret=1.
//  2. SW (0x0020A223) then LW -> STORE: mem_we=1, addr_sel=1, no reg_write; LOAD: wb_sel=1 in WB_MEM.
//  3. BEQ (0x00000463) with branch_taken=1 then 0 -> pc_write=1/pc_sel=1 vs pc_write=0; imm_sel=B both.
//  4. JALR (0x000080E7) -> JUMP: pc_sel=2, wb_sel=2, reg_write=1 same cycle.
//  5. Opcode 0x7F -> ERROR, o_illegal=1 sticky; ready held low 255 cyc in MEM_ACC -> ERROR; ready on cyc 255 -> no error.
//  6. Deassert i_rst_n mid MEM_ACC -> mem_req 0 same cycle, state FETCH; with/without CTRL_PERF_CNT_EN counters 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and opcode constants for the RV64I multicycle control FSM.
// No logic; consumed by ctrl_opdecode and multicycle_ctrl.
// No handshake; pure typedef/constant package.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_EXEC_U   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_ACC  = 4'd6,
        ST_WB_ALU   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_ERROR    = 4'd11
    } ctrl_state_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_fmt_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_TARGET = 2'd1,
        PC_ALU    = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        A_RS1   = 2'd0,
        A_OLDPC = 2'd1,
        A_ZERO  = 2'd2
    } alu_a_t;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } alu_b_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Everything the FSM needs to know about the instruction held in IR.
    typedef struct packed {
        ctrl_state_t nxt;      // state to take out of DECODE
        imm_fmt_t    imm;      // immediate format for the sign-extend path
        logic        is_store;
        logic        is_jalr;
        logic        is_lui;
    } opdec_t;

endpackage

// File: rtl/ctrl_opdecode.sv
// Opcode classifier: IR opcode -> DECODE successor, immediate format, flags.
// Purely combinational, zero latency.
// No handshake; output follows i_opcode.
module ctrl_opdecode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output opdec_t     o_dec
);

    // Map each supported major opcode to its execution path; anything else traps.
    always_comb begin
        o_dec = '{nxt: ST_ERROR, imm: IMM_I, is_store: 1'b0, is_jalr: 1'b0, is_lui: 1'b0};
        case (i_opcode)
            OPC_OP:     o_dec.nxt = ST_EXEC_R;
            OPC_OP_IMM: o_dec.nxt = ST_EXEC_I;
            OPC_LOAD:   o_dec.nxt = ST_MEM_ADDR;
            OPC_STORE: begin
                o_dec.nxt      = ST_MEM_ADDR;
                o_dec.imm      = IMM_S;
                o_dec.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                o_dec.nxt = ST_BRANCH;
                o_dec.imm = IMM_B;
            end
            OPC_JAL: begin
                o_dec.nxt = ST_JUMP;
                o_dec.imm = IMM_J;
            end
            OPC_JALR: begin
                o_dec.nxt     = ST_JUMP;
                o_dec.is_jalr = 1'b1;
            end
            OPC_LUI: begin
                o_dec.nxt    = ST_EXEC_U;
                o_dec.imm    = IMM_U;
                o_dec.is_lui = 1'b1;
            end
            OPC_AUIPC: begin
                o_dec.nxt = ST_EXEC_U;
                o_dec.imm = IMM_U;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV64I control FSM; optional perf counters under `CTRL_PERF_CNT_EN.
// 3-5 cycles per instruction plus memory wait; strobes are Moore except FETCH/BRANCH qualifiers.
// Stalls in FETCH/MEM_ACC until i_mem_ready; MEM_TIMEOUT_CYC idle cycles there traps to ERROR.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instr,
    input  logic        i_mem_ready,
    input  logic        i_branch_taken,
    output logic        o_pc_write,
    output logic [1:0]  o_pc_sel,
    output logic        o_ir_write,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_mem_addr_sel,
    output logic [2:0]  o_imm_sel,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_alu_op,
    output logic        o_reg_write,
    output logic [1:0]  o_wb_sel,
    output logic        o_illegal,
    output logic [3:0]  o_state,
    output logic [63:0] o_cycle_cnt,
    output logic [63:0] o_instret_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT_CYC < 2) ? 1 : $clog2(MEM_TIMEOUT_CYC);

    ctrl_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout;
    opdec_t            dec;

    // Only the major opcode steers control; the remaining IR fields belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^i_instr[31:7];

    ctrl_opdecode u_opdecode (
        .i_opcode (i_instr[6:0]),
        .o_dec    (dec)
    );

    // Wait count N means N cycles already spent in this memory state without ready.
    assign mem_timeout = (MEM_TIMEOUT_CYC != 0) &&
                         (wait_cnt_q == WAIT_W'(MEM_TIMEOUT_CYC - 1));

    // State and memory-wait counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic; ready in the final allowed wait cycle still completes the access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (i_mem_ready)      state_d = ST_DECODE;
                else if (mem_timeout) state_d = ST_ERROR;
            end
            ST_DECODE:   state_d = dec.nxt;
            ST_EXEC_R,
            ST_EXEC_I,
            ST_EXEC_U:   state_d = ST_WB_ALU;
            ST_MEM_ADDR: state_d = ST_MEM_ACC;
            ST_MEM_ACC: begin
                if (i_mem_ready)      state_d = dec.is_store ? ST_FETCH : ST_WB_MEM;
                else if (mem_timeout) state_d = ST_ERROR;
            end
            ST_WB_ALU,
            ST_WB_MEM,
            ST_BRANCH,
            ST_JUMP:     state_d = ST_FETCH;
            ST_ERROR:    state_d = ST_ERROR;
            default:     state_d = ST_ERROR;
        endcase
        // Counter only runs while parked in a memory state; any entry or exit clears it.
        wait_cnt_d = '0;
        if ((state_q == ST_FETCH || state_q == ST_MEM_ACC) && state_d == state_q)
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    // Output decode; reset low forces every strobe off without waiting for a clock.
    always_comb begin
        pc_sel_t  pc_sel;
        imm_fmt_t imm_sel;
        alu_a_t   src_a;
        alu_b_t   src_b;
        alu_op_t  alu_op;
        wb_sel_t  wb_sel;
        o_pc_write     = 1'b0;
        o_ir_write     = 1'b0;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr_sel = 1'b0;
        o_reg_write    = 1'b0;
        pc_sel         = PC_PLUS4;
        imm_sel        = IMM_I;
        src_a          = A_RS1;
        src_b          = B_RS2;
        alu_op         = ALU_ADD;
        wb_sel         = WB_ALU;
        if (i_rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    o_mem_req  = 1'b1;
                    o_ir_write = i_mem_ready;
                    o_pc_write = i_mem_ready;
                end
                ST_DECODE: begin
                    src_a = A_OLDPC;
                    src_b = B_IMM;
                end
                ST_EXEC_R: alu_op = ALU_FUNCT;
                ST_EXEC_I: begin
                    src_b  = B_IMM;
                    alu_op = ALU_FUNCT;
                end
                ST_EXEC_U: begin
                    src_a = dec.is_lui ? A_ZERO : A_OLDPC;
                    src_b = B_IMM;
                end
                ST_MEM_ADDR: src_b = B_IMM;
                ST_MEM_ACC: begin
                    o_mem_req      = 1'b1;
                    o_mem_addr_sel = 1'b1;
                    o_mem_we       = dec.is_store;
                end
                ST_WB_ALU: o_reg_write = 1'b1;
                ST_WB_MEM: begin
                    o_reg_write = 1'b1;
                    wb_sel      = WB_MEM;
                end
                ST_BRANCH: begin
                    alu_op     = ALU_SUB;
                    o_pc_write = i_branch_taken;
                    pc_sel     = PC_TARGET;
                end
                ST_JUMP: begin
                    // JAL reuses the old_pc+imm from DECODE; JALR needs rs1+imm now.
                    o_reg_write = 1'b1;
                    wb_sel      = WB_PC4;
                    o_pc_write  = 1'b1;
                    pc_sel      = dec.is_jalr ? PC_ALU : PC_TARGET;
                    if (dec.is_jalr) src_b = B_IMM;
                end
                default: ;
            endcase
            if (state_q != ST_FETCH && state_q != ST_ERROR) imm_sel = dec.imm;
        end
        o_pc_sel    = pc_sel;
        o_imm_sel   = imm_sel;
        o_alu_src_a = src_a;
        o_alu_src_b = src_b;
        o_alu_op    = alu_op;
        o_wb_sel    = wb_sel;
    end

    assign o_illegal = (state_q == ST_ERROR);
    assign o_state   = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [63:0] cycle_cnt_q, instret_cnt_q;
    logic        retire;

    assign retire = (state_d == ST_FETCH) && (state_q != ST_FETCH) && (state_q != ST_ERROR);

    // Cycle and retire counters; both hold their value once trapped in ERROR.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else if (state_q != ST_ERROR) begin
            cycle_cnt_q <= cycle_cnt_q + 64'd1;
            if (retire) instret_cnt_q <= instret_cnt_q + 64'd1;
        end
    end

    assign o_cycle_cnt   = cycle_cnt_q;
    assign o_instret_cnt = instret_cnt_q;
`else
    assign o_cycle_cnt   = 64'd0;
    assign o_instret_cnt = 64'd0;
`endif

endmodule
